// File: rtl/microsequencer_if.sv
// Microword/sequencer bus: microword fields, flags and IR flow into the sequencer,
// and the control-store address plus stall/state flow back out.
interface microsequencer_if #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_FLAGS       = 4
);
    logic [DATAWIDTH_CONDITION-1:0]   MICROSEQUENCER_Condition_InBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_JumpAddress_InBus;
    logic                             MICROSEQUENCER_RD_In;
    logic                             MICROSEQUENCER_WRMain_In;
    logic                             MICROSEQUENCER_MemReady_In;
    logic [DATAWIDTH_FLAGS-1:0]       MICROSEQUENCER_Flags_InBus;
    logic                             MICROSEQUENCER_FlagsLoad_In;
    logic [DATAWIDTH_IR-1:0]          MICROSEQUENCER_IR_InBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] MICROSEQUENCER_CSAddress_OutBus;
    logic                             MICROSEQUENCER_Stall_Out;
    logic [1:0]                       MICROSEQUENCER_State_OutBus;

    // Handshake: a memory request is RD|WR; while it is high and MemReady is low the
    // sequencer holds its address and raises Stall. MemReady is ignored without a request.
    modport master (
        output MICROSEQUENCER_Condition_InBus, MICROSEQUENCER_JumpAddress_InBus,
               MICROSEQUENCER_RD_In, MICROSEQUENCER_WRMain_In, MICROSEQUENCER_MemReady_In,
               MICROSEQUENCER_Flags_InBus, MICROSEQUENCER_FlagsLoad_In, MICROSEQUENCER_IR_InBus,
        input  MICROSEQUENCER_CSAddress_OutBus, MICROSEQUENCER_Stall_Out, MICROSEQUENCER_State_OutBus
    );

    modport slave (
        input  MICROSEQUENCER_Condition_InBus, MICROSEQUENCER_JumpAddress_InBus,
               MICROSEQUENCER_RD_In, MICROSEQUENCER_WRMain_In, MICROSEQUENCER_MemReady_In,
               MICROSEQUENCER_Flags_InBus, MICROSEQUENCER_FlagsLoad_In, MICROSEQUENCER_IR_InBus,
        output MICROSEQUENCER_CSAddress_OutBus, MICROSEQUENCER_Stall_Out, MICROSEQUENCER_State_OutBus
    );
endinterface

// File: rtl/microsequencer.sv
// Control-store address sequencer: next/branch/decode select, memory-wait stall, post-reset fetch start.
// Optional macro MICROSEQUENCER_PSR_EN: flag conditions test a latched PSR instead of the live flags.
module microsequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_FLAGS       = 4
) (
    input  logic          MICROSEQUENCER_CLOCK_50,
    input  logic          MICROSEQUENCER_ResetInHigh_In,
    microsequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [DATAWIDTH_JUMPADDRESS-1:0] r_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] w_addr_next;
    logic [DATAWIDTH_JUMPADDRESS-1:0] w_branch_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] w_decode_addr;
    logic [DATAWIDTH_FLAGS-1:0]       w_flags;
    logic                             w_cond_true;
    logic                             w_mem_req;
    logic                             w_stall;

    assign w_mem_req = bus.MICROSEQUENCER_RD_In | bus.MICROSEQUENCER_WRMain_In;
    assign w_stall   = (r_state == ST_WAIT);

`ifdef MICROSEQUENCER_PSR_EN
    logic [DATAWIDTH_FLAGS-1:0] r_psr;

    always_ff @(posedge MICROSEQUENCER_CLOCK_50 or posedge MICROSEQUENCER_ResetInHigh_In) begin
        if (MICROSEQUENCER_ResetInHigh_In)
            r_psr <= '0;
        else if (bus.MICROSEQUENCER_FlagsLoad_In && !w_stall)
            r_psr <= bus.MICROSEQUENCER_Flags_InBus;
    end

    assign w_flags = r_psr;
`else
    logic w_unused_flagsload;
    assign w_flags            = bus.MICROSEQUENCER_Flags_InBus;
    assign w_unused_flagsload = bus.MICROSEQUENCER_FlagsLoad_In;
`endif

    // Only op, op3 and the i bit of the IR steer the sequencer.
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, bus.MICROSEQUENCER_IR_InBus[29:25],
                           bus.MICROSEQUENCER_IR_InBus[18:14], bus.MICROSEQUENCER_IR_InBus[12:0]};

    // Decode target: 1, op[1:0], op3[5:0], 00 -- four microwords per opcode slot.
    assign w_decode_addr = {1'b1, bus.MICROSEQUENCER_IR_InBus[31:30],
                            bus.MICROSEQUENCER_IR_InBus[24:19], 2'b00};

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.MICROSEQUENCER_Condition_InBus)
            3'd1:    w_cond_true = w_flags[3];
            3'd2:    w_cond_true = w_flags[2];
            3'd3:    w_cond_true = w_flags[1];
            3'd4:    w_cond_true = w_flags[0];
            3'd5:    w_cond_true = bus.MICROSEQUENCER_IR_InBus[13];
            3'd6:    w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        w_branch_addr = r_addr + DATAWIDTH_JUMPADDRESS'(1);
        if (bus.MICROSEQUENCER_Condition_InBus == 3'd7)
            w_branch_addr = w_decode_addr;
        else if (w_cond_true)
            w_branch_addr = bus.MICROSEQUENCER_JumpAddress_InBus;
    end

    // START holds address 0 for one edge so the fetch microword after reset is executed.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        case (r_state)
            ST_START: begin
                w_state_next = ST_RUN;
                w_addr_next  = '0;
            end
            ST_RUN, ST_WAIT: begin
                if (w_mem_req && !bus.MICROSEQUENCER_MemReady_In) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_RUN;
                    w_addr_next  = w_branch_addr;
                end
            end
            default: begin
                w_state_next = ST_START;
                w_addr_next  = '0;
            end
        endcase
    end

    always_ff @(posedge MICROSEQUENCER_CLOCK_50 or posedge MICROSEQUENCER_ResetInHigh_In) begin
        if (MICROSEQUENCER_ResetInHigh_In) begin
            r_state <= ST_START;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
        end
    end

    assign bus.MICROSEQUENCER_CSAddress_OutBus = r_addr;
    assign bus.MICROSEQUENCER_Stall_Out        = w_stall;
    assign bus.MICROSEQUENCER_State_OutBus     = r_state;
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: reset/START, increment, decode, IR/flag branches,
// memory wait, wrap-around and asynchronous reset during a wait.
module tb_microsequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    microsequencer_if bus ();

    microsequencer dut (
        .MICROSEQUENCER_CLOCK_50       (clk),
        .MICROSEQUENCER_ResetInHigh_In (rst),
        .bus                           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] cond, input logic [10:0] jump,
                         input logic rd, input logic wr, input logic rdy,
                         input logic [3:0] flags, input logic fload, input logic [31:0] ir);
        bus.MICROSEQUENCER_Condition_InBus   = cond;
        bus.MICROSEQUENCER_JumpAddress_InBus = jump;
        bus.MICROSEQUENCER_RD_In             = rd;
        bus.MICROSEQUENCER_WRMain_In         = wr;
        bus.MICROSEQUENCER_MemReady_In       = rdy;
        bus.MICROSEQUENCER_Flags_InBus       = flags;
        bus.MICROSEQUENCER_FlagsLoad_In      = fload;
        bus.MICROSEQUENCER_IR_InBus          = ir;
    endtask

    // One rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [10:0] target);
        drive(3'd6, target, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_reset();
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd0) begin
            n_err++; $display("FAIL reset_addr: got %0d want 0", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        n_cmp++;
        if (bus.MICROSEQUENCER_State_OutBus !== 2'b00 || bus.MICROSEQUENCER_Stall_Out !== 1'b0) begin
            n_err++; $display("FAIL reset_state: got state=%b stall=%b want 00/0",
                              bus.MICROSEQUENCER_State_OutBus, bus.MICROSEQUENCER_Stall_Out);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd0 || bus.MICROSEQUENCER_State_OutBus !== 2'b01) begin
            n_err++; $display("FAIL start_hold: got addr=%0d state=%b want 0/01",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_State_OutBus);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
            step();
            n_cmp++;
            if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'(i)) begin
                n_err++; $display("FAIL incr_%0d: got %0d want %0d", i, bus.MICROSEQUENCER_CSAddress_OutBus, i);
            end
        end
    endtask

    task automatic test_decode();
        jump_to(11'd1);
        drive(3'd7, 11'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h8080_0000);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd1600) begin
            n_err++; $display("FAIL decode_addcc: got %0d want 1600", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
    endtask

    task automatic test_ir13_branch();
        drive(3'd5, 11'd1602, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0000_2000);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd1602) begin
            n_err++; $display("FAIL ir13_taken: got %0d want 1602", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        jump_to(11'd1600);
        drive(3'd5, 11'd1602, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'hFFFF_DFFF);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd1601) begin
            n_err++; $display("FAIL ir13_not_taken: got %0d want 1601", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
    endtask

    task automatic test_mem_wait();
        jump_to(11'd0);
        drive(3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd0 || bus.MICROSEQUENCER_Stall_Out !== 1'b1 ||
                bus.MICROSEQUENCER_State_OutBus !== 2'b10) begin
                n_err++; $display("FAIL wait_hold_%0d: got addr=%0d stall=%b state=%b want 0/1/10", i,
                                  bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_Stall_Out,
                                  bus.MICROSEQUENCER_State_OutBus);
            end
        end
        bus.MICROSEQUENCER_MemReady_In = 1'b1;
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd1 || bus.MICROSEQUENCER_Stall_Out !== 1'b0 ||
            bus.MICROSEQUENCER_State_OutBus !== 2'b01) begin
            n_err++; $display("FAIL wait_release: got addr=%0d stall=%b state=%b want 1/0/01",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_Stall_Out,
                              bus.MICROSEQUENCER_State_OutBus);
        end
        // RD and WR together with ready already high: one request, no stall.
        drive(3'd0, 11'd0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd2 || bus.MICROSEQUENCER_State_OutBus !== 2'b01) begin
            n_err++; $display("FAIL rdwr_ready: got addr=%0d state=%b want 2/01",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_State_OutBus);
        end
        // WR alone without ready stalls too.
        drive(3'd0, 11'd0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd2 || bus.MICROSEQUENCER_Stall_Out !== 1'b1) begin
            n_err++; $display("FAIL wr_stall: got addr=%0d stall=%b want 2/1",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_Stall_Out);
        end
        bus.MICROSEQUENCER_MemReady_In = 1'b1;
        step();
        // MemReady with no request is ignored: plain increment.
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd4) begin
            n_err++; $display("FAIL ready_no_req: got %0d want 4", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
    endtask

    task automatic test_wrap();
        jump_to(11'd2047);
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd0) begin
            n_err++; $display("FAIL wrap: got %0d want 0", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
    endtask

    // Flags are loaded one cycle before each branch so both PSR and live-flag builds agree.
    task automatic test_flag_branch();
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h0);
        step();
        drive(3'd2, 11'd5, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd5) begin
            n_err++; $display("FAIL z_taken: got %0d want 5", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 32'h0);
        step();
        drive(3'd2, 11'd100, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd7) begin
            n_err++; $display("FAIL z_not_taken: got %0d want 7", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        drive(3'd1, 11'd20, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd20) begin
            n_err++; $display("FAIL n_taken: got %0d want 20", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        drive(3'd3, 11'd40, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd40) begin
            n_err++; $display("FAIL v_taken: got %0d want 40", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
        drive(3'd4, 11'd60, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd60) begin
            n_err++; $display("FAIL c_taken: got %0d want 60", bus.MICROSEQUENCER_CSAddress_OutBus);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(3'd0, 11'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd60 || bus.MICROSEQUENCER_State_OutBus !== 2'b10) begin
            n_err++; $display("FAIL pre_reset_wait: got addr=%0d state=%b want 60/10",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_State_OutBus);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd0 || bus.MICROSEQUENCER_State_OutBus !== 2'b00 ||
            bus.MICROSEQUENCER_Stall_Out !== 1'b0) begin
            n_err++; $display("FAIL async_reset_wait: got addr=%0d state=%b stall=%b want 0/00/0",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_State_OutBus,
                              bus.MICROSEQUENCER_Stall_Out);
        end
        drive(3'd0, 11'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if (bus.MICROSEQUENCER_CSAddress_OutBus !== 11'd1 || bus.MICROSEQUENCER_State_OutBus !== 2'b01) begin
            n_err++; $display("FAIL restart_after_wait: got addr=%0d state=%b want 1/01",
                              bus.MICROSEQUENCER_CSAddress_OutBus, bus.MICROSEQUENCER_State_OutBus);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_back_to_back();
        test_decode();
        test_ir13_branch();
        test_mem_wait();
        test_wrap();
        test_flag_branch();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
